// File: rtl/spi_flash_reader.sv
// Single-SPI NOR flash read engine: wakes the flash (0xAB) after reset, then serves 32-bit READ (0x03) word fetches.
// Latency: read_ready pulses 1+128*CLK_DIV cycles after read_valid is accepted in IDLE.
// Backpressure: one read in flight; read_valid is only sampled in IDLE and must stay high until accepted.
// Ports: clk/reset (sync, active-high); read_valid/read_addr in, read_ready/read_data out (little-endian word);
//        flash_clk (SCK mode 0), flash_csn, io0 = MOSI (driven), io1 = MISO (input only), io0_in ignored.
module spi_flash_reader #(
    parameter int CLK_DIV       = 1,
    parameter int RELEASE_DELAY = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        read_valid,
    input  logic [23:0] read_addr,
    output logic        read_ready,
    output logic [31:0] read_data,
    output logic        flash_clk,
    output logic        flash_csn,
    output logic        flash_io0_en,
    output logic        flash_io0_out,
    input  logic        flash_io0_in,
    output logic        flash_io1_en,
    output logic        flash_io1_out,
    input  logic        flash_io1_in
);
    localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int WAIT_MAX = (RELEASE_DELAY > 2 * CLK_DIV) ? RELEASE_DELAY : 2 * CLK_DIV;
    localparam int WAIT_W   = $clog2(WAIT_MAX + 1);

    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [WAIT_W-1:0] REL_LAST = WAIT_W'(RELEASE_DELAY - 1);
    // DONE is the first high-csn cycle, so GAP covers the remaining 2*CLK_DIV-1.
    localparam logic [WAIT_W-1:0] GAP_LAST = WAIT_W'(2 * CLK_DIV - 2);
    localparam logic [7:0]        WAKE_CMD = 8'hAB;
    localparam logic [7:0]        READ_CMD = 8'h03;

    typedef enum logic [2:0] {
        WAKE_START, WAKE_SHIFT, WAKE_WAIT, IDLE, SHIFT, DONE, GAP
    } state_t;

    state_t             state_q,  state_d;
    logic [DIV_W-1:0]   div_q,    div_d;
    logic [5:0]         bit_q,    bit_d;
    logic [WAIT_W-1:0]  wait_q,   wait_d;
    logic [31:0]        tx_q,     tx_d;
    logic [31:0]        rx_q,     rx_d;
    logic               sck_q,    sck_d;
    logic               csn_q,    csn_d;
    logic               mosi_q,   mosi_d;
    logic               ready_q,  ready_d;
    logic [31:0]        data_q,   data_d;

    logic [31:0]        rx_shift;
    logic [5:0]         bit_last;
    logic               unused_io0_in;

    assign unused_io0_in = flash_io0_in;

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        bit_d    = bit_q;
        wait_d   = wait_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        sck_d    = sck_q;
        csn_d    = csn_q;
        mosi_d   = mosi_q;
        ready_d  = 1'b0;
        data_d   = data_q;
        rx_shift = {rx_q[30:0], flash_io1_in};
        bit_last = (state_q == WAKE_SHIFT) ? 6'd7 : 6'd63;

        case (state_q)
            WAKE_START: begin
                // tx_q holds the bits still to send; bit 7 goes straight to MOSI.
                csn_d   = 1'b0;
                sck_d   = 1'b0;
                mosi_d  = WAKE_CMD[7];
                tx_d    = {WAKE_CMD[6:0], 25'd0};
                bit_d   = '0;
                div_d   = '0;
                state_d = WAKE_SHIFT;
            end
            WAKE_SHIFT, SHIFT: begin
                if (div_q != DIV_LAST) begin
                    div_d = div_q + DIV_W'(1);
                end else begin
                    div_d = '0;
                    if (!sck_q) begin
                        sck_d = 1'b1;
                    end else begin
                        // This edge ends the SCK-high phase: sample MISO, then start the next bit.
                        sck_d = 1'b0;
                        if (bit_q[5]) begin
                            rx_d = rx_shift;
                        end
                        if (bit_q == bit_last) begin
                            csn_d  = 1'b1;
                            mosi_d = 1'b0;
                            wait_d = '0;
                            bit_d  = '0;
                            if (state_q == WAKE_SHIFT) begin
                                state_d = WAKE_WAIT;
                            end else begin
                                state_d = DONE;
                                ready_d = 1'b1;
                                // First received byte lands in the low byte of the word.
                                data_d  = {rx_shift[7:0], rx_shift[15:8],
                                           rx_shift[23:16], rx_shift[31:24]};
                            end
                        end else begin
                            bit_d  = bit_q + 6'd1;
                            mosi_d = tx_q[31];
                            tx_d   = {tx_q[30:0], 1'b0};
                        end
                    end
                end
            end
            WAKE_WAIT: begin
                if (wait_q == REL_LAST) begin
                    state_d = IDLE;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            IDLE: begin
                if (read_valid) begin
                    // The address lives only in tx_q from here on, so later read_addr changes are ignored.
                    csn_d   = 1'b0;
                    sck_d   = 1'b0;
                    mosi_d  = READ_CMD[7];
                    tx_d    = {READ_CMD[6:0], read_addr, 1'b0};
                    bit_d   = '0;
                    div_d   = '0;
                    state_d = SHIFT;
                end
            end
            DONE: begin
                wait_d  = '0;
                state_d = GAP;
            end
            GAP: begin
                if (wait_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            default: begin
                state_d = WAKE_START;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= WAKE_START;
            div_q   <= '0;
            bit_q   <= '0;
            wait_q  <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            sck_q   <= 1'b0;
            csn_q   <= 1'b1;
            mosi_q  <= 1'b0;
            ready_q <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            wait_q  <= wait_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            sck_q   <= sck_d;
            csn_q   <= csn_d;
            mosi_q  <= mosi_d;
            ready_q <= ready_d;
            data_q  <= data_d;
        end
    end

    assign read_ready    = ready_q;
    assign read_data     = data_q;
    assign flash_clk     = sck_q;
    assign flash_csn     = csn_q;
    assign flash_io0_en  = 1'b1;
    assign flash_io0_out = mosi_q;
    assign flash_io1_en  = 1'b0;
    assign flash_io1_out = 1'b0;

endmodule

// File: tb/tb_spi_flash_reader.sv
// Bench for spi_flash_reader: two instances (CLK_DIV=1 and CLK_DIV=3), each with a behavioural SPI flash model.
// Expected timing comes from the bit-level rules (16*D wake, 128*D read, R release cycles); data from the model.
module tb_spi_flash_reader;
    localparam int R = 8;

    logic             clk = 1'b0;
    logic [1:0]       rst;
    logic [1:0]       vld;
    logic [1:0][23:0] raddr;
    logic [1:0][31:0] mword;
    logic [1:0]       io0_in;
    wire  [1:0]       rdy, sck, csn, mosi, io0_en, io1_en, io1_out;
    wire  [1:0][31:0] rdata;
    wire  [1:0][7:0]  m_cmd_w;
    wire  [1:0][23:0] m_addr_w;
    wire  [1:0][6:0]  m_nbits_w;
    wire  [1:0][7:0]  mon_err_w;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;
    always @(negedge clk) io0_in = 2'($urandom);

    for (genvar g = 0; g < 2; g++) begin : gi
        localparam int D = (g == 0) ? 1 : 3;
        logic        miso  = 1'b0;
        int          cnt   = 0;
        logic [31:0] sh    = '0;
        logic [7:0]  cmd   = '0;
        logic [23:0] adr   = '0;
        int          nbits = 0;
        logic        pcsn  = 1'b1;
        logic        psck  = 1'b0;
        int          merr  = 0;
        int          run   = 0;
        logic        mcsn  = 1'b1;
        logic        msck  = 1'b0;
        logic        mmosi = 1'b0;

        spi_flash_reader #(.CLK_DIV(D), .RELEASE_DELAY(R)) u_dut (
            .clk(clk), .reset(rst[g]), .read_valid(vld[g]), .read_addr(raddr[g]),
            .read_ready(rdy[g]), .read_data(rdata[g]), .flash_clk(sck[g]), .flash_csn(csn[g]),
            .flash_io0_en(io0_en[g]), .flash_io0_out(mosi[g]), .flash_io0_in(io0_in[g]),
            .flash_io1_en(io1_en[g]), .flash_io1_out(io1_out[g]), .flash_io1_in(miso)
        );

        // Flash: shifts in command+address on SCK rise, shifts data out on SCK fall, bytes MSB first.
        always @(sck[g] or csn[g]) begin
            if (csn[g] !== pcsn) begin
                if (csn[g] === 1'b0) begin
                    cnt = 0; sh = '0; miso = 1'b0;
                end else if (pcsn === 1'b0) begin
                    nbits = cnt;
                    if (cnt <= 8) cmd = sh[7:0];
                    else begin cmd = sh[31:24]; adr = sh[23:0]; end
                end
            end else if (csn[g] === 1'b0 && sck[g] !== psck) begin
                if (sck[g] === 1'b1) begin
                    if (cnt < 32) sh = {sh[30:0], mosi[g]};
                    cnt++;
                end else if (cnt >= 32 && cnt < 64) begin
                    miso = mword[g][8 * ((cnt - 32) / 8) + 7 - ((cnt - 32) % 8)];
                end
            end
            pcsn = csn[g]; psck = sck[g];
        end

        // Pad monitor: SCK phases are D cycles, MOSI moves only with SCK falling, SCK low while deselected.
        always @(negedge clk) begin
            if (csn[g] === 1'b0 && mcsn === 1'b0) begin
                if (sck[g] === msck) run++;
                else begin
                    if (run != D) merr++;
                    run = 1;
                end
                if (mosi[g] !== mmosi && !(msck === 1'b1 && sck[g] === 1'b0)) merr++;
            end else begin
                run = 1;
                if (csn[g] === 1'b1 && sck[g] === 1'b1) merr++;
            end
            if (io0_en[g] !== 1'b1 || io1_en[g] !== 1'b0 || io1_out[g] !== 1'b0) merr++;
            mcsn = csn[g]; msck = sck[g]; mmosi = mosi[g];
        end

        assign m_cmd_w[g]   = cmd;
        assign m_addr_w[g]  = adr;
        assign m_nbits_w[g] = 7'(nbits);
        assign mon_err_w[g] = 8'(merr);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int div_of(input int g);
        return (g == 0) ? 1 : 3;
    endfunction

    // Current cycle is T+n0 (T = acceptance cycle). chg>0: at cycle T+chg scribble the address and drop valid.
    task automatic run_read(input int g, input logic [23:0] a, input logic [31:0] w,
                            input bit hold, input int n0, input int chg);
        int d, lat;
        logic [31:0] got;
        d = div_of(g);
        mword[g] = w; raddr[g] = a; vld[g] = 1'b1;
        lat = -1; got = '0;
        for (int n = n0 + 1; n <= 128 * d + 16; n++) begin
            step();
            if (n == 1) check("csn_low_after_accept", 32'(csn[g]), 32'd0);
            if (n == chg) begin raddr[g] = 24'hFFFFFF; vld[g] = 1'b0; end
            if (rdy[g] === 1'b1) begin lat = n; got = rdata[g]; break; end
        end
        check("ready_latency", 32'(lat), 32'(1 + 128 * d));
        check("read_data", got, w);
        check("flash_cmd", 32'(m_cmd_w[g]), 32'h03);
        check("flash_addr", 32'(m_addr_w[g]), 32'(a));
        check("flash_bits", 32'(m_nbits_w[g]), 32'd64);
        if (!hold) begin
            vld[g] = 1'b0;
            step();
            check("ready_one_cycle", 32'(rdy[g]), 32'd0);
            check("data_hold", rdata[g], w);
            repeat (8 * d + 8) step();
        end
    endtask

    // Precondition: rst[g] high. Releases reset with valid held through the whole wake sequence.
    task automatic wake_and_read(input int g, input logic [23:0] a, input logic [31:0] w);
        int d, lows, highs;
        d = div_of(g); lows = 0; highs = 0;
        mword[g] = w; raddr[g] = a; vld[g] = 1'b1;
        rst[g] = 1'b0;
        for (int c = 1; c <= 1 + 16 * d + R; c++) begin
            step();
            if (c <= 16 * d) begin
                if (csn[g] === 1'b0) lows++;
            end else if (csn[g] === 1'b1) begin
                highs++;
            end
            if (c == 16 * d + 1) begin
                check("wake_cmd", 32'(m_cmd_w[g]), 32'hAB);
                check("wake_bits", 32'(m_nbits_w[g]), 32'd8);
            end
        end
        check("wake_csn_low_cycles", 32'(lows), 32'(16 * d));
        check("wake_release_cycles", 32'(highs), 32'(R + 1));
        run_read(g, a, w, 1'b0, 0, 0);
    endtask

    initial begin
        int d, hi;
        logic [31:0] w2;
        rst = 2'b11; vld = '0; raddr = '0; mword = '0;
        repeat (3) step();
        for (int g = 0; g < 2; g++) begin
            check("rst_csn", 32'(csn[g]), 32'd1);
            check("rst_sck", 32'(sck[g]), 32'd0);
            check("rst_mosi", 32'(mosi[g]), 32'd0);
            check("rst_ready", 32'(rdy[g]), 32'd0);
            check("rst_data", rdata[g], 32'd0);
        end

        for (int g = 0; g < 2; g++) begin
            d = div_of(g);
            wake_and_read(g, 24'h001234, 32'hDEADBEEF);
            repeat (3) run_read(g, 24'($urandom), $urandom, 1'b0, 0, 0);

            // Back-to-back: valid stays high with a new address straight after the ready pulse.
            run_read(g, 24'($urandom), $urandom, 1'b1, 0, 0);
            w2 = $urandom;
            raddr[g] = 24'h000004; mword[g] = w2;
            hi = 1;
            for (int k = 0; k < 8 * d + 8; k++) begin
                step();
                if (csn[g] === 1'b1) hi++;
                else break;
            end
            check("b2b_gap_min", 32'(hi >= 2 * d), 32'd1);
            check("b2b_gap_bounded", 32'(csn[g]), 32'd0);
            run_read(g, 24'h000004, w2, 1'b0, 1, 0);

            // Address scribbled and valid dropped during bit 10.
            run_read(g, 24'h000100, $urandom, 1'b0, 0, 1 + 20 * d);

            // Reset at the first cycle of bit 40, then full wake and a normal read.
            mword[g] = $urandom; raddr[g] = 24'($urandom); vld[g] = 1'b1;
            for (int n = 1; n <= 1 + 80 * d; n++) step();
            rst[g] = 1'b1;
            step();
            check("abort_csn", 32'(csn[g]), 32'd1);
            check("abort_sck", 32'(sck[g]), 32'd0);
            check("abort_ready", 32'(rdy[g]), 32'd0);
            check("abort_data", rdata[g], 32'd0);
            check("abort_bits", 32'(m_nbits_w[g]), 32'd40);
            vld[g] = 1'b0;
            step();
            check("abort_ready_2", 32'(rdy[g]), 32'd0);
            wake_and_read(g, 24'($urandom), $urandom);
        end

        check("pad_monitor_div1", 32'(mon_err_w[0]), 32'd0);
        check("pad_monitor_div3", 32'(mon_err_w[1]), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/spi_flash_reader.md
Name: spi_flash_reader

Overview:
- Single-SPI NOR flash read engine. It sits between the SoC's memory-mapped flash window and the bidirectional pad cells of flash_io0 and flash_io1.
- It wakes the flash from deep power-down after reset.
- It then serves 32-bit word reads with the standard READ command (0x03) and a 24-bit address.
- Its pad-side outputs connect directly to flash_clk, flash_csn and the io0/io1 en/in/out nets.

Parameters:
CLK_DIV, 1, clk cycles per SCK half-period; legal values are 1 or more.
RELEASE_DELAY, 8, clk cycles between the end of the wake command and the first accepted read (flash tRES1).

Ports:
clk  input  1  system clock (PLL clock domain)
reset  input  1  synchronous, active-high reset
read_valid  input  1  read request; held high until read_ready
read_addr  input  24  byte address; latched on acceptance
read_ready  output  1  one-cycle pulse; read_data is valid in that cycle
read_data  output  32  assembled word, little-endian
flash_clk  output  1  SPI SCK, mode 0
flash_csn  output  1  chip select, active low
flash_io0_en  output  1  io0 output enable; constant 1 (MOSI)
flash_io0_out  output  1  MOSI data
flash_io0_in  input  1  unused; must not affect behaviour
flash_io1_en  output  1  io1 output enable; constant 0 (MISO)
flash_io1_out  output  1  constant 0
flash_io1_in  input  1  MISO data

Behaviour:
- Clock/reset: one clock, clk. Reset is synchronous and active-high.
- All outputs are registered. Values while reset is high: flash_csn=1, flash_clk=0, flash_io0_out=0, read_ready=0, read_data=0, state=WAKE_START.
- States: WAKE_START, WAKE_SHIFT, WAKE_WAIT, IDLE, SHIFT, DONE, GAP.
- Cycle 0 is the first cycle with reset low.
  - WAKE_START: csn goes low at cycle 1 and 0xAB is shifted MSB first.
  - WAKE_SHIFT: lasts 8 bits × 2*CLK_DIV cycles.
  - WAKE_WAIT: csn goes high at cycle 1+16*CLK_DIV and stays high for RELEASE_DELAY cycles, then the state is IDLE.
  - read_valid is ignored in every state except IDLE.
- Bit timing (mode 0): each bit is 2*CLK_DIV cycles.
  - flash_io0_out changes only on the first cycle of the bit, while SCK=0.
  - SCK=0 for CLK_DIV cycles, then SCK=1 for CLK_DIV cycles.
  - flash_io1_in is sampled on the clk edge ending the last SCK=1 cycle of the bit.
- IDLE: flash_csn=1, flash_clk=0. If read_valid=1 in cycle T:
  - read_addr is latched;
  - csn=0 from T+1 and the first command bit is driven at T+1.
- SHIFT: 64 bits in total.
  - Bits 0–31 on MOSI: 0x03 then addr[23:0], MSB first.
  - MOSI is 0 during bits 32–63.
  - Bits 32–63 are captured from MISO, each byte MSB first.
  - Received byte k (k=0..3) goes to read_data[8k+7:8k].
- DONE: cycle T+1+128*CLK_DIV. csn=1, SCK=0, read_ready=1 for exactly one cycle, read_data updated.
  - read_data holds its value until the next DONE.
  - For CLK_DIV=1 the latency is 129 cycles from acceptance.
- GAP: csn stays high for at least 2*CLK_DIV cycles after DONE (including the DONE cycle), then IDLE.
  - A valid already high is accepted on the first IDLE cycle.
- Boundary conditions:
  - read_addr changes after acceptance are ignored.
  - read_valid dropping mid-transaction does not abort the transaction; the ready pulse still occurs.
  - Address wrap (0xFFFFFC and above) is the flash's concern; the address is passed through unmodified.
- Reset mid-operation (any state): next cycle csn=1, SCK=0, no read_ready. The full wake sequence reruns.
- Bit counter is 6 bits; the half-period counter is wide enough for CLK_DIV.

Test Plan:
1. Reset then release, CLK_DIV=1, flash model attached:
   - csn low for cycles 1..16;
   - model decodes 0xAB;
   - csn high for ≥8 cycles before any read is accepted.
2. Read: read_valid held with read_addr=0x001234 at cycle T; model returns bytes EF,BE,AD,DE:
   - model sees command 0x03 and address 0x001234;
   - read_ready=1 only at T+129 with read_data=0xDEADBEEF.
3. CLK_DIV=3, same read:
   - SCK low/high phases exactly 3 cycles each;
   - MOSI is stable across each rising edge;
   - read_ready at T+385.
4. Back-to-back reads, valid held with new addr 0x000004 immediately after read_ready:
   - csn high for ≥2*CLK_DIV cycles between transactions;
   - second read_data is correct.
5. Change read_addr to 0xFFFFFF during bit 10 of a read at 0x000100:
   - model receives 0x000100.
6. Assert reset during bit 40:
   - csn=1 and SCK=0 the next cycle;
   - no read_ready;
   - after release, 0xAB is re-sent, then a normal read succeeds.
